// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the 2-master/2-slave AXI read arbiter.
//   rd_state_e   : read sequencing state (also the Read_State_control encoding)
//   R_*          : route codes {master, default, s1, s0} seen on ARID_control
//   SEL_*        : bit positions inside the 3-bit one-hot decoder select
//   inWindow()   : inclusive unsigned address window test
//   routeCode()  : builds a route code from a master index and decoder select
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_ADDR   = 2'b00,
        ST_DATA   = 2'b01,
        ST_DECERR = 2'b10
    } rd_state_e;

    localparam logic [3:0] R_NONE  = 4'b0000;
    localparam logic [3:0] R_M0S0  = 4'b0001;
    localparam logic [3:0] R_M0S1  = 4'b0010;
    localparam logic [3:0] R_M0DEF = 4'b0100;
    localparam logic [3:0] R_M1S0  = 4'b1001;
    localparam logic [3:0] R_M1S1  = 4'b1010;
    localparam logic [3:0] R_M1DEF = 4'b1100;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    localparam int SEL_S0  = 0;
    localparam int SEL_S1  = 1;
    localparam int SEL_DEF = 2;

    // Borrow-based compare keeps the test unsigned and avoids a constant
    // comparison when a window starts at address zero.
    function automatic logic inWindow(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
        logic [32:0] fromBase;
        logic [32:0] toLimit;
        fromBase = {1'b0, addr} - {1'b0, base};
        toLimit  = {1'b0, limit} - {1'b0, addr};
        return !fromBase[32] && !toLimit[32];
    endfunction

    function automatic logic [3:0] routeCode(input logic master,
                                             input logic [2:0] sel);
        return {master, sel};
    endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_if
// Bundles the AR/R handshake inputs and the control outputs of the read
// arbiter.
//   slave  modport : seen by the arbiter (bus signals in, control out)
//   master modport : seen by the environment driving the arbiter
// ---------------------------------------------------------------------------
interface axi_read_arbiter_if;

    logic        ARVALID_M0;
    logic        ARVALID_M1;
    logic [31:0] ARADDR_M0;
    logic [31:0] ARADDR_M1;
    logic [3:0]  ARLEN_M0;
    logic [3:0]  ARLEN_M1;
    logic [3:0]  ARID_M0;
    logic [3:0]  ARID_M1;
    logic        ARREADY_S0;
    logic        ARREADY_S1;
    logic        RVALID_S0;
    logic        RVALID_S1;
    logic        RLAST_S0;
    logic        RLAST_S1;
    logic        RREADY_M0;
    logic        RREADY_M1;

    logic [1:0]  Read_State_control;
    logic [3:0]  ARID_control;
    logic        DEF_ARREADY;
    logic        DEF_RVALID;
    logic        DEF_RLAST;
    logic [1:0]  DEF_RRESP;
    logic [7:0]  DEF_RID;

    modport slave (
        input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
        input  ARLEN_M0, ARLEN_M1, ARID_M0, ARID_M1,
        input  ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
        input  RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1,
        output Read_State_control, ARID_control,
        output DEF_ARREADY, DEF_RVALID, DEF_RLAST, DEF_RRESP, DEF_RID
    );

    modport master (
        output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1,
        output ARLEN_M0, ARLEN_M1, ARID_M0, ARID_M1,
        output ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1,
        output RLAST_S0, RLAST_S1, RREADY_M0, RREADY_M1,
        input  Read_State_control, ARID_control,
        input  DEF_ARREADY, DEF_RVALID, DEF_RLAST, DEF_RRESP, DEF_RID
    );

endinterface

// File: rtl/axi_addr_decoder.sv
// ---------------------------------------------------------------------------
// axi_addr_decoder
// Combinational address decoder for one master.
//   addr_i : read address
//   sel_o  : one-hot {DEF, S1, S0}; S0 wins where windows overlap
// ---------------------------------------------------------------------------
module axi_addr_decoder
    import axi_arb_pkg::*;
#(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_LIMIT = 32'h0000_FFFF,
    parameter logic [31:0] S1_BASE  = 32'h0001_0000,
    parameter logic [31:0] S1_LIMIT = 32'h0001_FFFF
) (
    input  logic [31:0] addr_i,
    output logic [2:0]  sel_o
);

    always_comb begin
        sel_o = '0;
        if (inWindow(addr_i, S0_BASE, S0_LIMIT)) begin
            sel_o[SEL_S0] = 1'b1;
        end else if (inWindow(addr_i, S1_BASE, S1_LIMIT)) begin
            sel_o[SEL_S1] = 1'b1;
        end else begin
            sel_o[SEL_DEF] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Round-robin read-path sequencer for two AXI masters and two slaves plus an
// embedded default slave that answers unmapped reads with DECERR bursts.
//   ACLK    : clock
//   ARESETn : synchronous active-low reset
//   bus     : AR/R handshake inputs; Read_State_control, ARID_control and the
//             DEF_* default-slave outputs
// ---------------------------------------------------------------------------
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S0_LIMIT = 32'h0000_FFFF,
    parameter logic [31:0] S1_BASE  = 32'h0001_0000,
    parameter logic [31:0] S1_LIMIT = 32'h0001_FFFF
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_read_arbiter_if.slave  bus
);

    rd_state_e  state_q;
    logic       rrPtr_q;
    logic [3:0] beatCnt_q;
    logic [3:0] route_q;
    logic [3:0] arId_q;
    logic       defRvalid_q;
    logic       defRlast_q;

    logic [2:0] selM0;
    logic [2:0] selM1;
    logic [2:0] winSel;
    logic       anyReq;
    logic       winner;
    logic [3:0] winLen;
    logic [3:0] winId;
    logic [3:0] arbRoute;
    logic       routedArready;
    logic       arHandshake;
    logic       routedRready;
    logic       slaveLastBeat;

    axi_addr_decoder #(
        .S0_BASE (S0_BASE),
        .S0_LIMIT(S0_LIMIT),
        .S1_BASE (S1_BASE),
        .S1_LIMIT(S1_LIMIT)
    ) u_decM0 (
        .addr_i(bus.ARADDR_M0),
        .sel_o (selM0)
    );

    axi_addr_decoder #(
        .S0_BASE (S0_BASE),
        .S0_LIMIT(S0_LIMIT),
        .S1_BASE (S1_BASE),
        .S1_LIMIT(S1_LIMIT)
    ) u_decM1 (
        .addr_i(bus.ARADDR_M1),
        .sel_o (selM1)
    );

    // Grant is recomputed every ADDR cycle, so a winner that drops ARVALID
    // before its handshake simply loses the grant on the next cycle.
    always_comb begin
        anyReq        = bus.ARVALID_M0 | bus.ARVALID_M1;
        winner        = (bus.ARVALID_M0 & bus.ARVALID_M1) ? rrPtr_q : bus.ARVALID_M1;
        winSel        = winner ? selM1 : selM0;
        winLen        = winner ? bus.ARLEN_M1 : bus.ARLEN_M0;
        winId         = winner ? bus.ARID_M1 : bus.ARID_M0;
        arbRoute      = anyReq ? routeCode(winner, winSel) : R_NONE;
        routedArready = (winSel[SEL_S0] & bus.ARREADY_S0)
                      | (winSel[SEL_S1] & bus.ARREADY_S1)
                      |  winSel[SEL_DEF];
        arHandshake   = (state_q == ST_ADDR) && anyReq && routedArready;
        routedRready  = route_q[3] ? bus.RREADY_M1 : bus.RREADY_M0;
        slaveLastBeat = (route_q[SEL_S0] & bus.RVALID_S0 & bus.RLAST_S0)
                      | (route_q[SEL_S1] & bus.RVALID_S1 & bus.RLAST_S1);
    end

    // The beat counter holds the remaining DECERR beats minus one, so the
    // last beat is flagged one cycle ahead when the counter steps 1 -> 0.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= ST_ADDR;
            rrPtr_q     <= 1'b0;
            beatCnt_q   <= '0;
            route_q     <= R_NONE;
            arId_q      <= '0;
            defRvalid_q <= 1'b0;
            defRlast_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (arHandshake) begin
                        route_q   <= arbRoute;
                        arId_q    <= winId;
                        beatCnt_q <= winLen;
                        rrPtr_q   <= ~winner;
                        if (winSel[SEL_DEF]) begin
                            state_q     <= ST_DECERR;
                            defRvalid_q <= 1'b1;
                            defRlast_q  <= (winLen == 4'd0);
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (slaveLastBeat && routedRready) begin
                        state_q <= ST_ADDR;
                        route_q <= R_NONE;
                    end
                end
                ST_DECERR: begin
                    if (routedRready) begin
                        if (beatCnt_q == 4'd0) begin
                            state_q     <= ST_ADDR;
                            route_q     <= R_NONE;
                            defRvalid_q <= 1'b0;
                            defRlast_q  <= 1'b0;
                        end else begin
                            beatCnt_q  <= beatCnt_q - 4'd1;
                            defRlast_q <= (beatCnt_q == 4'd1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_ADDR;
                end
            endcase
        end
    end

    assign bus.Read_State_control = state_q;
    assign bus.ARID_control       = (state_q == ST_ADDR) ? arbRoute : route_q;
    assign bus.DEF_ARREADY        = (state_q == ST_ADDR) && anyReq && winSel[SEL_DEF];
    assign bus.DEF_RVALID         = defRvalid_q;
    assign bus.DEF_RLAST          = defRlast_q;
    assign bus.DEF_RRESP          = defRvalid_q ? RRESP_DECERR : RRESP_OKAY;
    assign bus.DEF_RID            = defRvalid_q ? {4'b0000, arId_q} : 8'h00;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter
// Self-checking bench for axi_read_arbiter: a table of single-cycle ADDR
// decode/grant vectors followed by hand-written multi-cycle bursts. Each
// cycle's expected outputs are queued when the stimulus is driven and
// popped when the DUT outputs are sampled.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter;

    logic ACLK;
    logic ARESETn;

    axi_read_arbiter_if bus();

    axi_read_arbiter dut (
        .ACLK   (ACLK),
        .ARESETn(ARESETn),
        .bus    (bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct {
        logic [1:0] st;
        logic [3:0] route;
        logic       dar;
        logic       drv;
        logic       drl;
        logic [1:0] drr;
        logic [7:0] drid;
    } exp_t;

    typedef struct {
        logic        arv0;
        logic        arv1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [3:0]  expRoute;
        logic        expDar;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[11];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        bus.ARVALID_M0 = 1'b0;
        bus.ARVALID_M1 = 1'b0;
        bus.ARADDR_M0  = 32'h0;
        bus.ARADDR_M1  = 32'h0;
        bus.ARLEN_M0   = 4'h0;
        bus.ARLEN_M1   = 4'h0;
        bus.ARID_M0    = 4'h0;
        bus.ARID_M1    = 4'h0;
        bus.ARREADY_S0 = 1'b0;
        bus.ARREADY_S1 = 1'b0;
        bus.RVALID_S0  = 1'b0;
        bus.RVALID_S1  = 1'b0;
        bus.RLAST_S0   = 1'b0;
        bus.RLAST_S1   = 1'b0;
        bus.RREADY_M0  = 1'b0;
        bus.RREADY_M1  = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        exp_t        e;
        logic [18:0] act;
        logic [18:0] req;
        checks++;
        if (sbQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, no expectation queued", name);
        end else begin
            e   = sbQ.pop_front();
            act = {bus.Read_State_control, bus.ARID_control, bus.DEF_ARREADY,
                   bus.DEF_RVALID, bus.DEF_RLAST, bus.DEF_RRESP, bus.DEF_RID};
            req = {e.st, e.route, e.dar, e.drv, e.drl, e.drr, e.drid};
            if (act !== req) begin
                failures++;
                $display("[TB] FAIL %s: got st=%b route=%b dar=%b rv=%b rl=%b rr=%b rid=%h, want st=%b route=%b dar=%b rv=%b rl=%b rr=%b rid=%h",
                         name, act[18:17], act[16:13], act[12], act[11], act[10], act[9:8], act[7:0],
                         req[18:17], req[16:13], req[12], req[11], req[10], req[9:8], req[7:0]);
            end
        end
    endtask

    // Queue the expectation for the inputs just driven, sample mid-cycle,
    // then advance to just after the next rising edge.
    task automatic step(input string name, input logic [1:0] st, input logic [3:0] route,
                        input logic dar, input logic drv, input logic drl, input logic [7:0] rid);
        exp_t e;
        e.st    = st;
        e.route = route;
        e.dar   = dar;
        e.drv   = drv;
        e.drl   = drl;
        e.drr   = drv ? 2'b11 : 2'b00;
        e.drid  = rid;
        sbQ.push_back(e);
        #2;
        checkOutput(name);
        @(posedge ACLK);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        ARESETn = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        idleInputs();
        bus.ARVALID_M0 = v.arv0;
        bus.ARVALID_M1 = v.arv1;
        bus.ARADDR_M0  = v.addr0;
        bus.ARADDR_M1  = v.addr1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0001, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0000, 4'b0001, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0000_0000, 4'b0010, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0001_FFFF, 32'h0000_0000, 4'b0010, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0002_0000, 32'h0000_0000, 4'b0100, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1001, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0001_ABCD, 4'b1010, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1100, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 32'h0001_0000, 32'h0000_0000, 4'b0010, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0000_0000, 4'b0000, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h0003_0000, 32'h0000_0100, 4'b0100, 1'b1};

        idleInputs();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        step("reset_state", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        // Single-cycle grant/decode vectors, each from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            doReset();
            applyStimulus(vecs[i]);
            step($sformatf("vec%0d", i), 2'b00, vecs[i].expRoute, vecs[i].expDar, 1'b0, 1'b0, 8'h00);
        end

        // M0 -> S0 four-beat burst; an M1 request during DATA is ignored.
        doReset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h0000_0040; bus.ARLEN_M0 = 4'd3;
        bus.ARID_M0 = 4'd1; bus.ARREADY_S0 = 1'b1;
        step("A_ar", 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S0 = 1'b0;
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0001_0000;
        bus.RVALID_S0 = 1'b1; bus.RREADY_M0 = 1'b1;
        step("A_b1", 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S0 = 1'b0;
        step("A_gap", 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S0 = 1'b1;
        step("A_b2", 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        step("A_b3", 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RLAST_S0 = 1'b1;
        step("A_b4", 2'b01, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);
        idleInputs();
        step("A_done", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        // Both masters to S1: grants alternate M0, M1, M0.
        doReset();
        bus.ARVALID_M0 = 1'b1; bus.ARVALID_M1 = 1'b1;
        bus.ARADDR_M0 = 32'h0001_0000; bus.ARADDR_M1 = 32'h0001_0000;
        bus.ARREADY_S1 = 1'b1;
        step("B_g0", 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S1 = 1'b1; bus.RLAST_S1 = 1'b1; bus.RREADY_M0 = 1'b0; bus.RREADY_M1 = 1'b1;
        step("B_hold", 2'b01, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RREADY_M0 = 1'b1;
        step("B_last0", 2'b01, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S1 = 1'b0; bus.RLAST_S1 = 1'b0; bus.RREADY_M0 = 1'b0; bus.RREADY_M1 = 1'b0;
        step("B_g1", 2'b00, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S1 = 1'b1; bus.RLAST_S1 = 1'b1; bus.RREADY_M0 = 1'b1;
        step("B_wrongM", 2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RREADY_M0 = 1'b0; bus.RREADY_M1 = 1'b1;
        step("B_last1", 2'b01, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.RVALID_S1 = 1'b0; bus.RLAST_S1 = 1'b0; bus.RREADY_M1 = 1'b0;
        step("B_g2", 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00);

        // M1 unmapped read, three DECERR beats with a two-cycle stall.
        doReset();
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0002_0000; bus.ARLEN_M1 = 4'd2; bus.ARID_M1 = 4'd5;
        step("C_ar", 2'b00, 4'b1100, 1'b1, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M1 = 1'b0; bus.RREADY_M1 = 1'b1;
        step("C_b1", 2'b10, 4'b1100, 1'b0, 1'b1, 1'b0, 8'h05);
        bus.RREADY_M1 = 1'b0; bus.RREADY_M0 = 1'b1;
        step("C_hold1", 2'b10, 4'b1100, 1'b0, 1'b1, 1'b0, 8'h05);
        step("C_hold2", 2'b10, 4'b1100, 1'b0, 1'b1, 1'b0, 8'h05);
        bus.RREADY_M0 = 1'b0; bus.RREADY_M1 = 1'b1;
        step("C_b2", 2'b10, 4'b1100, 1'b0, 1'b1, 1'b0, 8'h05);
        step("C_b3", 2'b10, 4'b1100, 1'b0, 1'b1, 1'b1, 8'h05);
        bus.RREADY_M1 = 1'b0;
        step("C_idle", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset during beat 2 of a DECERR burst; round-robin pointer returns to M0.
        doReset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'h8000_0000; bus.ARLEN_M0 = 4'd15; bus.ARID_M0 = 4'hA;
        step("E_ar", 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M0 = 1'b0; bus.RREADY_M0 = 1'b1;
        step("E_b1", 2'b10, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h0A);
        ARESETn = 1'b0;
        step("E_b2rst", 2'b10, 4'b0100, 1'b0, 1'b1, 1'b0, 8'h0A);
        ARESETn = 1'b1; bus.RREADY_M0 = 1'b0;
        step("E_afterRst", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M0 = 1'b1; bus.ARVALID_M1 = 1'b1;
        bus.ARADDR_M0 = 32'h0000_0000; bus.ARADDR_M1 = 32'h0000_0000;
        step("E_rrPtr", 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00);

        // Single-beat DECERR (ARLEN=0).
        doReset();
        bus.ARVALID_M0 = 1'b1; bus.ARADDR_M0 = 32'hFFFF_FFFF; bus.ARLEN_M0 = 4'd0; bus.ARID_M0 = 4'd3;
        step("F_ar", 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M0 = 1'b0; bus.RREADY_M0 = 1'b1;
        step("F_b1", 2'b10, 4'b0100, 1'b0, 1'b1, 1'b1, 8'h03);
        bus.RREADY_M0 = 1'b0;
        step("F_done", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        // Sixteen-beat DECERR (ARLEN=15) from M1.
        bus.ARVALID_M1 = 1'b1; bus.ARADDR_M1 = 32'h0002_0000; bus.ARLEN_M1 = 4'd15; bus.ARID_M1 = 4'hF;
        step("G_ar", 2'b00, 4'b1100, 1'b1, 1'b0, 1'b0, 8'h00);
        bus.ARVALID_M1 = 1'b0; bus.RREADY_M1 = 1'b1;
        for (int b = 0; b < 16; b++) begin
            step($sformatf("G_b%0d", b), 2'b10, 4'b1100, 1'b0, 1'b1, (b == 15), 8'h0F);
        end
        bus.RREADY_M1 = 1'b0;
        step("G_done", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_drain: %0d entries left, want 0", sbQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
